// File: rtl/lcd_instr_sequencer.sv
// Feeds the LCD instruction FSM: power-up wait, init list, then MSG_LEN DDRAM chars; registered outputs, next_instruction lands the cycle after ISSUE.
// Each instruction waits for instr_done before the next is loaded; LCD_SEQ_REFRESH_EN makes the character pass repeat forever.
module lcd_instr_sequencer #(
  parameter int POWERUP_WAIT = 750000,
  parameter int CLEAR_WAIT   = 82000,
  parameter int MSG_LEN      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        instr_done,
  input  logic        instr_enable,
  output logic        next_instruction,
  output logic [11:0] clk_cnt,
  output logic [9:0]  db,
  output logic [4:0]  char_addr,
  input  logic [7:0]  char_data,
  output logic        busy,
  output logic        seq_done
);

  localparam logic [19:0] PWR_LAST  = 20'(POWERUP_WAIT - 1);
  localparam logic [19:0] CLR_LAST  = 20'(CLEAR_WAIT - 1);
  localparam logic [4:0]  LAST_CHAR = 5'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_WAIT, S_LOAD, S_ISSUE, S_WAIT_DONE, S_CLR_WAIT, S_ADVANCE, S_FINISHED
  } state_e;

  typedef enum logic [2:0] {
    E_FUNC, E_ENTRY, E_DISP, E_CLEAR, E_ADDR1, E_ADDR2, E_CHAR
  } entry_e;

  state_e      state_q, state_d;
  entry_e      entry_q, entry_d;
  logic [4:0]  k_q, k_d;
  logic [19:0] wait_q, wait_d;
  logic [9:0]  db_q, db_d;
  logic        ni_q, ni_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] clk_cnt_q;
  logic [9:0]  entry_val;

  always_comb begin
    entry_val = 10'h000;
    case (entry_q)
      E_FUNC:  entry_val = 10'h028;
      E_ENTRY: entry_val = 10'h006;
      E_DISP:  entry_val = 10'h00C;
      E_CLEAR: entry_val = 10'h001;
      E_ADDR1: entry_val = 10'h080;
      E_ADDR2: entry_val = 10'h0C0;
      E_CHAR:  entry_val = {2'b10, char_data};
      default: entry_val = 10'h000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    k_d     = k_q;
    wait_d  = '0;
    db_d    = db_q;
    ni_d    = 1'b0;
    busy_d  = busy_q;
`ifdef LCD_SEQ_REFRESH_EN
    done_d  = 1'b0;
`else
    done_d  = done_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWR_WAIT;
          busy_d  = 1'b1;
          entry_d = E_FUNC;
          k_d     = '0;
        end
      end
      S_PWR_WAIT: begin
        if (wait_q == PWR_LAST) state_d = S_LOAD;
        else                    wait_d  = wait_q + 20'd1;
      end
      S_LOAD: begin
        db_d    = entry_val;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ni_d    = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (instr_done) state_d = (entry_q == E_CLEAR) ? S_CLR_WAIT : S_ADVANCE;
      end
      S_CLR_WAIT: begin
        if (wait_q == CLR_LAST) state_d = S_ADVANCE;
        else                    wait_d  = wait_q + 20'd1;
      end
      S_ADVANCE: begin
        state_d = S_LOAD;
        case (entry_q)
          E_ADDR1: begin
            entry_d = E_CHAR;
            k_d     = '0;
          end
          E_ADDR2: entry_d = E_CHAR;
          E_CHAR: begin
            if (k_q == LAST_CHAR) begin
`ifdef LCD_SEQ_REFRESH_EN
              entry_d = E_ADDR1;
              k_d     = '0;
              done_d  = 1'b1;
`else
              state_d = S_FINISHED;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              k_d = k_q + 5'd1;
              // Line 2 starts at char 16; re-address DDRAM before writing it.
              if (k_q == 5'd15) entry_d = E_ADDR2;
            end
          end
          default: entry_d = entry_e'(entry_q + 3'd1);
        endcase
      end
      S_FINISHED: begin
        if (start) begin
          state_d = S_PWR_WAIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          entry_d = E_FUNC;
          k_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      entry_q <= E_FUNC;
      k_q     <= '0;
      wait_q  <= '0;
      db_q    <= '0;
      ni_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      db_q    <= db_d;
      ni_q    <= ni_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Timebase runs only while the downstream FSM has an instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   clk_cnt_q <= '0;
    else if (!instr_enable)       clk_cnt_q <= '0;
    else if (clk_cnt_q != 12'hFFF) clk_cnt_q <= clk_cnt_q + 12'd1;
  end

  assign next_instruction = ni_q;
  assign clk_cnt          = clk_cnt_q;
  assign db               = db_q;
  assign char_addr        = k_q;
  assign busy             = busy_q;
  assign seq_done         = done_q;

endmodule

// File: tb/tb_lcd_instr_sequencer.sv
// Bench for lcd_instr_sequencer: emulates the downstream instruction FSM with random response times.
module tb_lcd_instr_sequencer;
  localparam int PW = 10;
  localparam int CW = 20;
  localparam int ML = 18;

  logic        clk = 1'b0;
  logic        reset, start, instr_done, instr_enable;
  logic        next_instruction, busy, seq_done;
  logic [11:0] clk_cnt;
  logic [9:0]  db;
  logic [4:0]  char_addr;
  logic [7:0]  char_data;
  logic [7:0]  tbl [32];
  logic [9:0]  exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ni_cnt = 0;

  always #5 clk = ~clk;
  assign char_data = tbl[char_addr];
  always @(negedge clk) if (next_instruction === 1'b1) ni_cnt++;

  lcd_instr_sequencer #(.POWERUP_WAIT(PW), .CLEAR_WAIT(CW), .MSG_LEN(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_done(instr_done),
    .instr_enable(instr_enable), .next_instruction(next_instruction),
    .clk_cnt(clk_cnt), .db(db), .char_addr(char_addr), .char_data(char_data),
    .busy(busy), .seq_done(seq_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ni(output int c);
    c = 0;
    while (next_instruction !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    if (next_instruction !== 1'b1) chk("ni_timeout", {31'd0, next_instruction}, 1);
  endtask

  // Expected instruction stream: init list, line-1 address, chars with line-2 address before char 16.
  task automatic build_model();
    exp_q = {10'h028, 10'h006, 10'h00C, 10'h001, 10'h080};
    for (int k = 0; k < ML; k++) begin
      if (k == 16) exp_q.push_back(10'h0C0);
      exp_q.push_back({2'b10, tbl[k]});
    end
  endtask

  task automatic run_pass(input bit noise);
    int c, n, elapsed, min_gap, base, sd;
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    elapsed = 1;
    chk("busy_after_start", {31'd0, busy}, 1);
    if (noise) begin
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      elapsed++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_ni(c);
      if (i == 0) begin
        chk("first_latency", c + elapsed, 13);
      end else begin
        min_gap = (exp_q[i-1] == 10'h001) ? 2 + CW : 2;
        chk("gap_min", {31'd0, c >= min_gap}, 1);
      end
      chk("db_issue", {22'd0, db}, {22'd0, exp_q[i]});
      tick();
      chk("ni_pulse", {31'd0, next_instruction}, 0);
      n = $urandom_range(1, 30);
      instr_enable = 1'b1;
      start = ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
      repeat (n - 1) tick();
      chk("clk_cnt_run", {20'd0, clk_cnt}, n);
      chk("db_hold", {22'd0, db}, {22'd0, exp_q[i]});
      instr_enable = 1'b0;
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      chk("clk_cnt_clr", {20'd0, clk_cnt}, 0);
    end
`ifdef LCD_SEQ_REFRESH_EN
    c = 0;
    sd = 0;
    while (next_instruction !== 1'b1 && c < 200) begin
      tick();
      c++;
      if (seq_done === 1'b1) sd++;
    end
    chk("refresh_db", {22'd0, db}, 10'h080);
    chk("refresh_done_pulse", sd, 1);
    base = ni_cnt;
`else
    c = 0;
    while (seq_done !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    chk("seq_done", {31'd0, seq_done}, 1);
    chk("busy_end", {31'd0, busy}, 0);
    base = ni_cnt;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    repeat (20) tick();
    chk("finished_quiet", ni_cnt, base);
    chk("seq_done_hold", {31'd0, seq_done}, 1);
`endif
  endtask

  initial begin
    int c, base;
    reset = 1'b0; start = 1'b0; instr_done = 1'b0; instr_enable = 1'b0;
    for (int k = 0; k < 32; k++) tbl[k] = 8'(8'h41 + k);
    repeat (3) tick();
    chk("rst_db", {22'd0, db}, 0);
    chk("rst_ni", {31'd0, next_instruction}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_seq_done", {31'd0, seq_done}, 0);
    chk("rst_clk_cnt", {20'd0, clk_cnt}, 0);
    chk("rst_char_addr", {27'd0, char_addr}, 0);
    reset = 1'b1;
    tick();

    instr_enable = 1'b1;
    repeat (7) tick();
    chk("clk_cnt_7", {20'd0, clk_cnt}, 7);
    repeat (4993) tick();
    chk("clk_cnt_sat", {20'd0, clk_cnt}, 4095);
    instr_enable = 1'b0;
    tick();
    chk("clk_cnt_drop", {20'd0, clk_cnt}, 0);
    chk("idle_no_ni", ni_cnt, 0);
    chk("idle_busy", {31'd0, busy}, 0);

    run_pass(1'b0);
`ifndef LCD_SEQ_REFRESH_EN
    for (int k = 0; k < 32; k++) tbl[k] = 8'($urandom_range(0, 255));
    run_pass(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ni(c);
    chk("rerun_db", {22'd0, db}, 10'h028);
`endif

    tick();
    instr_enable = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("midrst_db", {22'd0, db}, 0);
    chk("midrst_ni", {31'd0, next_instruction}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_seq_done", {31'd0, seq_done}, 0);
    chk("midrst_clk_cnt", {20'd0, clk_cnt}, 0);
    chk("midrst_char_addr", {27'd0, char_addr}, 0);
    instr_enable = 1'b0;
    tick();
    reset = 1'b1;
    base = ni_cnt;
    repeat (40) tick();
    chk("post_rst_quiet", ni_cnt, base);
    chk("post_rst_busy", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
